// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response
// channel, and the decoder-facing valid/ready instruction port.
interface instruction_fetch_unit_if #(
   parameter int INST_W   = 16,
   parameter int I_ADDR_W = 12
);
   logic                redirect_valid;
   logic [I_ADDR_W-1:0] redirect_target;
   logic                imem_req_valid;
   logic                imem_req_ready;
   logic [I_ADDR_W-1:0] imem_req_addr;
   logic                imem_rsp_valid;
   logic [INST_W-1:0]   imem_rsp_data;
   logic [INST_W-1:0]   instruction;
   logic [I_ADDR_W-1:0] instruction_pc;
   logic                instruction_valid;
   logic                instruction_ready;

   modport master (
      input  redirect_valid, redirect_target,
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid, imem_rsp_data,
      output instruction, instruction_pc, instruction_valid,
      input  instruction_ready
   );

   modport slave (
      output redirect_valid, redirect_target,
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid, imem_rsp_data,
      input  instruction, instruction_pc, instruction_valid,
      output instruction_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// In-order instruction fetch with a small prefetch queue; a redirect flushes the
// queue and drains responses to requests issued before the redirect.
module instruction_fetch_unit #(
   parameter int                INST_W          = 16,
   parameter int                I_ADDR_W        = 12,
   parameter int                QUEUE_DEPTH     = 2,
   parameter logic [INST_W-1:0] NOP_INSTRUCTION = '0
) (
   input logic                     clk,
   input logic                     reset,
   instruction_fetch_unit_if.master bus
);
   localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

   typedef enum logic {RUN, DRAIN} state_t;

   state_t              state, state_next;
   logic [I_ADDR_W-1:0] fetch_pc;
   logic [CNT_W-1:0]    count, outstanding, outstanding_next;
   logic [CNT_W-1:0]    drop_count, drop_count_next;
   logic [PTR_W-1:0]    q_head, q_tail, tag_head, tag_tail;
   logic [INST_W-1:0]   q_data [QUEUE_DEPTH];
   logic [I_ADDR_W-1:0] q_pc   [QUEUE_DEPTH];
   logic [I_ADDR_W-1:0] tag_pc [QUEUE_DEPTH];
   logic                req_valid, req_fire, rsp_fire, push, pop, head_valid;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit check uses the registered count: a same-cycle pop frees nothing.
   always_comb begin
      head_valid       = (count != '0);
      req_valid        = !reset && (state == RUN) && !bus.redirect_valid &&
                         (({1'b0, count} + {1'b0, outstanding}) < (CNT_W + 1)'(QUEUE_DEPTH));
      req_fire         = req_valid && bus.imem_req_ready;
      rsp_fire         = bus.imem_rsp_valid;
      push             = (state == RUN) && !bus.redirect_valid && rsp_fire;
      pop              = head_valid && bus.instruction_ready;
      outstanding_next = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
      state_next       = state;
      drop_count_next  = drop_count;
      if (bus.redirect_valid) begin
         drop_count_next = outstanding_next;
         state_next      = (outstanding_next != '0) ? DRAIN : RUN;
      end else if ((state == DRAIN) && rsp_fire) begin
         drop_count_next = drop_count - CNT_W'(1);
         if (drop_count_next == '0) state_next = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         fetch_pc    <= '0;
         count       <= '0;
         outstanding <= '0;
         drop_count  <= '0;
         q_head      <= '0;
         q_tail      <= '0;
         tag_head    <= '0;
         tag_tail    <= '0;
      end else begin
         state       <= state_next;
         drop_count  <= drop_count_next;
         outstanding <= outstanding_next;
         if (req_fire) begin
            fetch_pc <= fetch_pc + I_ADDR_W'(1);
            tag_tail <= ptr_inc(tag_tail);
         end
         if (bus.redirect_valid) fetch_pc <= bus.redirect_target;
         // Tags pop on every response, stale or not, so they stay aligned.
         if (rsp_fire) tag_head <= ptr_inc(tag_head);
         if (bus.redirect_valid) begin
            count  <= '0;
            q_head <= '0;
            q_tail <= '0;
         end else begin
            if (push) q_tail <= ptr_inc(q_tail);
            if (pop)  q_head <= ptr_inc(q_head);
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) tag_pc[tag_tail] <= fetch_pc;
      if (push) begin
         q_data[q_tail] <= bus.imem_rsp_data;
         q_pc[q_tail]   <= tag_pc[tag_head];
      end
   end

   assign bus.imem_req_valid    = req_valid;
   assign bus.imem_req_addr     = fetch_pc;
   assign bus.instruction_valid = head_valid;
   assign bus.instruction       = head_valid ? q_data[q_head] : NOP_INSTRUCTION;
   assign bus.instruction_pc    = head_valid ? q_pc[q_head]   : '0;

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push && !pop && (count == CNT_W'(QUEUE_DEPTH))));
   a_credit: assert property (@(posedge clk) disable iff (reset)
      (({1'b0, count} + {1'b0, outstanding}) <= (CNT_W + 1)'(QUEUE_DEPTH)));
   a_drain_underflow: assert property (@(posedge clk) disable iff (reset)
      !((state == DRAIN) && rsp_fire && (drop_count == '0)));
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed per-cycle vector bench for instruction_fetch_unit with an in-order
// fixed-latency instruction memory model (data = 16'hA000 | address).
module tb_instruction_fetch_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   instruction_fetch_unit_if #(.INST_W(16), .I_ADDR_W(12)) bus ();

   instruction_fetch_unit #(
      .INST_W(16), .I_ADDR_W(12), .QUEUE_DEPTH(2), .NOP_INSTRUCTION(16'h0000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // lat != 0 starts a new phase: reset, then memory latency = lat.
   typedef struct {
      int          lat;
      logic        ir, mr, rd;
      logic [11:0] tgt;
      logic        rv;
      logic [11:0] ra;
      logic        iv;
      logic [15:0] ins;
      logic [11:0] pc;
   } vec_t;

   typedef struct {
      int          due;
      logic [11:0] addr;
   } pend_t;

   vec_t  vecs[$];
   pend_t pend[$];
   int    checks   = 0;
   int    failures = 0;
   int    edge_no  = 0;
   int    lat_cur  = 1;

   function automatic void add(input int lat, input logic ir, input logic mr, input logic rd,
                               input logic [11:0] tgt, input logic rv, input logic [11:0] ra,
                               input logic iv, input logic [15:0] ins, input logic [11:0] pc);
      vec_t v;
      v.lat = lat; v.ir = ir; v.mr = mr; v.rd = rd; v.tgt = tgt;
      v.rv = rv; v.ra = ra; v.iv = iv; v.ins = ins; v.pc = pc;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input int row, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL row %0d %s got=%h exp=%h", row, nm, got, exp);
      end
   endtask

   // Entered and left at a negedge; leaves reset released for the next row.
   task automatic do_reset(input int lat);
      reset = 1'b1;
      bus.redirect_valid    = 1'b0;
      bus.redirect_target   = '0;
      bus.imem_req_ready    = 1'b0;
      bus.imem_rsp_valid    = 1'b0;
      bus.imem_rsp_data     = '0;
      bus.instruction_ready = 1'b0;
      repeat (2) begin
         @(posedge clk);
         edge_no++;
      end
      @(negedge clk);
      #1;
      chk("rst_req_valid", -1, 16'(bus.imem_req_valid), 16'h0);
      chk("rst_instr_valid", -1, 16'(bus.instruction_valid), 16'h0);
      chk("rst_instruction", -1, bus.instruction, 16'h0000);
      chk("rst_instr_pc", -1, 16'(bus.instruction_pc), 16'h0);
      pend.delete();
      lat_cur = lat;
      reset   = 1'b0;
   endtask

   task automatic apply(input int row);
      vec_t        v;
      logic        fire;
      logic [11:0] faddr;
      pend_t       p;
      v = vecs[row];
      bus.instruction_ready = v.ir;
      bus.imem_req_ready    = v.mr;
      bus.redirect_valid    = v.rd;
      bus.redirect_target   = v.tgt;
      if (pend.size() > 0 && pend[0].due == edge_no + 1) begin
         assert (pend[0].due > edge_no) else $error("FAIL rsp_protocol row %0d", row);
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = 16'hA000 | {4'h0, pend[0].addr};
         void'(pend.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = '0;
      end
      #1;
      chk("req_valid", row, 16'(bus.imem_req_valid), 16'(v.rv));
      chk("req_addr", row, 16'(bus.imem_req_addr), 16'(v.ra));
      chk("instr_valid", row, 16'(bus.instruction_valid), 16'(v.iv));
      chk("instruction", row, bus.instruction, v.ins);
      chk("instr_pc", row, 16'(bus.instruction_pc), 16'(v.pc));
      fire  = bus.imem_req_valid && bus.imem_req_ready;
      faddr = bus.imem_req_addr;
      @(posedge clk);
      edge_no++;
      if (fire) begin
         p.due  = edge_no + lat_cur;
         p.addr = faddr;
         pend.push_back(p);
      end
      @(negedge clk);
   endtask

   initial begin
      // Steady flow, latency 1: credit limit gives two words every three cycles.
      add(1, 1,1,0,12'h000, 1,12'h000, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h001, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h002, 1,16'hA000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h002, 1,16'hA001,12'h001);
      add(0, 1,1,0,12'h000, 1,12'h003, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h004, 1,16'hA002,12'h002);
      add(0, 1,1,0,12'h000, 1,12'h004, 1,16'hA003,12'h003);
      // Decoder stalled 10 cycles: queue fills with PC 0,1, then drains in order.
      add(1, 0,1,0,12'h000, 1,12'h000, 0,16'h0000,12'h000);
      add(0, 0,1,0,12'h000, 1,12'h001, 0,16'h0000,12'h000);
      for (int i = 0; i < 8; i++)
         add(0, 0,1,0,12'h000, 0,12'h002, 1,16'hA000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h002, 1,16'hA000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h002, 1,16'hA001,12'h001);
      add(0, 1,1,0,12'h000, 1,12'h003, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h004, 1,16'hA002,12'h002);
      // Memory not ready for 3 cycles: address holds at 0.
      add(1, 1,0,0,12'h000, 1,12'h000, 0,16'h0000,12'h000);
      add(0, 1,0,0,12'h000, 1,12'h000, 0,16'h0000,12'h000);
      add(0, 1,0,0,12'h000, 1,12'h000, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h000, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h001, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h002, 1,16'hA000,12'h000);
      // Latency 3, redirect to 0x080 with two requests in flight.
      add(3, 1,1,0,12'h000, 1,12'h000, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h001, 0,16'h0000,12'h000);
      add(0, 1,1,1,12'h080, 0,12'h002, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h080, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h080, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h080, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h081, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h082, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h082, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h082, 1,16'hA080,12'h080);
      add(0, 1,1,0,12'h000, 1,12'h082, 1,16'hA081,12'h081);
      // PC wrap from 0xFFF to 0x000.
      add(1, 1,1,1,12'hFFF, 0,12'h000, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'hFFF, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h000, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h001, 1,16'hAFFF,12'hFFF);
      add(0, 1,1,0,12'h000, 1,12'h001, 1,16'hA000,12'h000);
      // Redirect together with a response and a pop: response dropped, queue empty.
      add(1, 1,1,0,12'h000, 1,12'h000, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h001, 0,16'h0000,12'h000);
      add(0, 1,1,1,12'h040, 0,12'h002, 1,16'hA000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h040, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h041, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h042, 1,16'hA040,12'h040);
      // Second redirect while draining keeps draining the remaining stale response.
      add(3, 1,1,0,12'h000, 1,12'h000, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h001, 0,16'h0000,12'h000);
      add(0, 1,1,1,12'h100, 0,12'h002, 0,16'h0000,12'h000);
      add(0, 1,1,1,12'h200, 0,12'h100, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 0,12'h200, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h200, 0,16'h0000,12'h000);
      add(0, 1,1,0,12'h000, 1,12'h201, 0,16'h0000,12'h000);

      reset                 = 1'b1;
      bus.redirect_valid    = 1'b0;
      bus.redirect_target   = '0;
      bus.imem_req_ready    = 1'b0;
      bus.imem_rsp_valid    = 1'b0;
      bus.imem_rsp_data     = '0;
      bus.instruction_ready = 1'b0;
      @(negedge clk);
      for (int r = 0; r < vecs.size(); r++) begin
         if (vecs[r].lat != 0) do_reset(vecs[r].lat);
         apply(r);
      end
      // Reset in mid-operation (requests outstanding) must clear everything.
      do_reset(1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
